punc_fetch_unit: RTL
====================

PUNC_FETCH_UNIT -- requirements
Module: punc_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 Parameters (name, default, meaning):
- TIMEOUT, 255, cycles to wait for mem_ack before aborting.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_req  in  1  start an instruction fetch at the current pc.
- pc_clr  in  1  set pc to 0x0000 and abort any fetch.
- pc_ld  in  1  load pc from the pc_sel source.
- pc_sel  in  2  0: pc+sext(ir[8:0]); 1: pc+sext(ir[10:0]); 2: rq_data; 3: reserved, hold pc.
- rq_data  in  16  register-file Rq data (JMP/JSRR target).
- ir_clr  in  1  clear ir.
- nzp_ld  in  1  capture condition codes from rf_w_data.
- nzp_clr  in  1  clear condition codes.
- rf_w_data  in  16  value being written to the register file.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  16  instruction memory address.
- mem_ack  in  1  memory read data valid.
- mem_rdata  in  16  memory read data.
- pc  out  16  program counter.
- ir  out  16  instruction register.
- nzp  out  3  condition codes {n,z,p}.
- nzp_match  out  1  |(ir[11:9] & nzp), combinational.
- busy  out  1  high while the FSM is in REQ.
- fetch_done  out  1  one-cycle pulse when ir is loaded.
- fetch_err  out  1  sticky timeout flag.

Function
REQ-004 The FSM SHALL have two states, IDLE and REQ.
- IDLE to REQ when fetch_req=1 and pc_clr=0.
- REQ to IDLE on mem_ack, on timeout, or on pc_clr.
REQ-005 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal the pc latched at entry, held stable until the FSM leaves REQ. In IDLE, mem_req SHALL be 0 and mem_addr SHALL equal pc.
REQ-006 On the cycle mem_ack=1 in REQ, the following SHALL happen at the next edge:
- ir <= mem_rdata;
- pc <= pc+1, modulo 2^16 (0xFFFF wraps to 0x0000);
- fetch_done pulses high for exactly one cycle;
- the watchdog clears.
REQ-007 mem_ack while in IDLE SHALL be ignored. fetch_req while in REQ SHALL be ignored.
REQ-008 The watchdog SHALL count cycles spent in REQ. When it reaches TIMEOUT with no ack:
- the FSM returns to IDLE and fetch_err is set;
- pc and ir are unchanged;
- fetch_done stays 0.
REQ-009 fetch_err SHALL stay set until reset or pc_clr.
REQ-010 pc update priority SHALL be pc_clr > fetch completion > pc_ld. pc_ld SHALL be ignored while busy=1.
REQ-011 pc_clr in REQ SHALL do all of the following at the next edge:
- abort the fetch and drop mem_req;
- set pc to 0x0000;
- leave ir unchanged;
- produce no fetch_done.
REQ-012 pc_sel offsets SHALL be sign-extended from ir bit 8 or bit 10, and added modulo 2^16.
REQ-013 ir_clr SHALL have priority over an ir load on the same edge.
REQ-014 On nzp_ld, the condition codes SHALL be n=rf_w_data[15], z=(rf_w_data==0), p=otherwise. Exactly one bit SHALL be set. nzp_clr SHALL have priority and give 3'b000.
REQ-015 nzp_match SHALL be combinational from the registered ir and nzp, with no added latency.

Reset
REQ-016 While rst=0 the block SHALL asynchronously hold the following, and release on the first clock edge after rst rises:
- pc=0x0000, ir=0x0000, nzp=3'b000;
- state IDLE, watchdog 0;
- mem_req=0, busy=0, fetch_done=0, fetch_err=0.
REQ-017 Reset asserted mid-fetch SHALL drop mem_req immediately, without waiting for a clock edge.

Verification
REQ-018 Basic fetch: pc=0x0000; fetch_req for one cycle; mem_ack with 0x1234 three cycles later. Required:
- mem_req high for 3 cycles with mem_addr=0x0000;
- then ir=0x1234, pc=0x0001, one fetch_done pulse.
REQ-019 Branch: ir=0x0E05 (BRnzp, offset 5), nzp=3'b001, pc=0x0010; pc_ld with pc_sel=0. Required: nzp_match=1 and pc=0x0015. Repeat with ir=0x01FF: required pc=0x000F.
REQ-020 Wrap and JMP:
- fetch at pc=0xFFFF completes: required pc=0x0000;
- pc_ld with pc_sel=2 and rq_data=0xBEEF: required pc=0xBEEF.
REQ-021 Timeout: fetch_req with mem_ack never asserted. Required:
- mem_req drops after 255 cycles;
- fetch_err=1, busy=0, pc and ir unchanged;
- a following pc_clr clears fetch_err.
REQ-022 Simultaneous events:
- pc_ld during REQ: ignored;
- pc_clr on the same cycle as mem_ack: pc=0x0000, ir unchanged, no fetch_done;
- nzp_ld with rf_w_data=0x8000: nzp=3'b100; with nzp_clr asserted together: nzp=3'b000.
REQ-023 Reset mid-fetch: drive rst low asynchronously while in REQ. Required: mem_req=0 immediately, and all outputs at the REQ-016 reset values.

Source files
------------

// File: rtl/punc_fetch_unit.sv
// punc_fetch_unit: program counter, instruction register and condition codes
// for the PUNC core, plus a two-state fetch sequencer that issues one
// instruction-memory read at a time and aborts it with a sticky error if
// memory never acknowledges.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no fetch outstanding; mem_addr follows pc, pc_ld is honoured
// REQ   | read outstanding at the latched address; watchdog running
module punc_fetch_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        pc_clr,
    input  logic        pc_ld,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] rq_data,
    input  logic        ir_clr,
    input  logic        nzp_ld,
    input  logic        nzp_clr,
    input  logic [15:0] rf_w_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic [2:0]  nzp,
    output logic        nzp_match,
    output logic        busy,
    output logic        fetch_done,
    output logic        fetch_err
);

    // The watchdog is a down-counter loaded on entry to REQ; expiry is the
    // cycle it is seen at zero, giving exactly TIMEOUT cycles in REQ.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wdog;
    logic [15:0]     addr_q;

    logic            start_fetch;
    logic            ack_hit;
    logic            wd_expire;
    logic [15:0]     pc_target;
    logic [15:0]     off9;
    logic [15:0]     off11;

    // Event decode for the current cycle.
    always_comb begin
        start_fetch = 1'b0;
        ack_hit     = 1'b0;
        wd_expire   = 1'b0;
        if (state == IDLE) begin
            start_fetch = fetch_req && !pc_clr;
        end else begin
            ack_hit   = mem_ack && !pc_clr;
            wd_expire = !mem_ack && !pc_clr && (wdog == '0);
        end
    end

    // Branch/jump target selection; offsets are sign-extended from ir.
    always_comb begin
        off9      = {{7{ir[8]}}, ir[8:0]};
        off11     = {{5{ir[10]}}, ir[10:0]};
        pc_target = pc;
        case (pc_sel)
            2'd0:    pc_target = pc + off9;
            2'd1:    pc_target = pc + off11;
            2'd2:    pc_target = rq_data;
            default: pc_target = pc;
        endcase
    end

    // Fetch sequencer: state, watchdog, latched address and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wdog       <= '0;
            addr_q     <= 16'h0000;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_fetch) begin
                        state  <= REQ;
                        wdog   <= WD_LOAD;
                        addr_q <= pc;
                    end
                end
                REQ: begin
                    if (pc_clr) begin
                        state <= IDLE;
                        wdog  <= '0;
                    end else if (mem_ack) begin
                        state      <= IDLE;
                        wdog       <= '0;
                        fetch_done <= 1'b1;
                    end else if (wd_expire) begin
                        state <= IDLE;
                        wdog  <= '0;
                    end else begin
                        wdog <= wdog - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    wdog  <= '0;
                end
            endcase

            // Error is sticky; only pc_clr (or reset) clears it.
            if (pc_clr) begin
                fetch_err <= 1'b0;
            end else if (wd_expire) begin
                fetch_err <= 1'b1;
            end
        end
    end

    // Program counter: clear beats fetch increment beats load; loads are
    // dropped while a fetch is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= 16'h0000;
        end else if (pc_clr) begin
            pc <= 16'h0000;
        end else if (ack_hit) begin
            pc <= pc + 16'h0001;
        end else if (pc_ld && (state == IDLE)) begin
            pc <= pc_target;
        end
    end

    // Instruction register: clear wins over a same-edge load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir <= 16'h0000;
        end else if (ir_clr) begin
            ir <= 16'h0000;
        end else if (ack_hit) begin
            ir <= mem_rdata;
        end
    end

    // Condition codes: one-hot {n,z,p} from the register-file write value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nzp <= 3'b000;
        end else if (nzp_clr) begin
            nzp <= 3'b000;
        end else if (nzp_ld) begin
            if (rf_w_data[15]) begin
                nzp <= 3'b100;
            end else if (rf_w_data == 16'h0000) begin
                nzp <= 3'b010;
            end else begin
                nzp <= 3'b001;
            end
        end
    end

    // Memory-side outputs derive from the state register so that reset
    // removes the request asynchronously.
    always_comb begin
        mem_req  = (state == REQ);
        busy     = (state == REQ);
        mem_addr = (state == REQ) ? addr_q : pc;
    end

    // Branch condition test against the current instruction.
    always_comb begin
        nzp_match = |(ir[11:9] & nzp);
    end

endmodule
